// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bus: ID-stage inputs and hazard controls in, per-stage control bits out.
// The core datapath holds the master side; ctrl_pipe holds the slave side.
interface ctrl_pipe_if #(
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 3
);
  logic               id_valid;
  logic [5:0]         id_op;
  logic [RA_W-1:0]    id_rs;
  logic [RA_W-1:0]    id_rt;
  logic [RA_W-1:0]    id_rd;
  logic               stall_ext;
  logic               ex_taken;

  logic               stall_id;
  logic               flush_if;
  logic               illegal;
  logic               ex_regwrite;
  logic               ex_alusrc;
  logic               ex_branch;
  logic               ex_bne;
  logic               ex_memwrite;
  logic               ex_memtoreg;
  logic               ex_lb;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [RA_W-1:0]    ex_wa;
  logic               mem_regwrite;
  logic               mem_memwrite;
  logic               mem_memtoreg;
  logic               mem_lb;
  logic [RA_W-1:0]    mem_wa;
  logic               wb_regwrite;
  logic               wb_memtoreg;
  logic [RA_W-1:0]    wb_wa;

  modport slave (
    input  id_valid, id_op, id_rs, id_rt, id_rd, stall_ext, ex_taken,
    output stall_id, flush_if, illegal,
           ex_regwrite, ex_alusrc, ex_branch, ex_bne, ex_memwrite, ex_memtoreg, ex_lb,
           ex_aluop, ex_wa,
           mem_regwrite, mem_memwrite, mem_memtoreg, mem_lb, mem_wa,
           wb_regwrite, wb_memtoreg, wb_wa
  );

  modport master (
    output id_valid, id_op, id_rs, id_rt, id_rd, stall_ext, ex_taken,
    input  stall_id, flush_if, illegal,
           ex_regwrite, ex_alusrc, ex_branch, ex_bne, ex_memwrite, ex_memtoreg, ex_lb,
           ex_aluop, ex_wa,
           mem_regwrite, mem_memwrite, mem_memtoreg, mem_lb, mem_wa,
           wb_regwrite, wb_memtoreg, wb_wa
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipelined main decoder for the 5-stage MIPS core: decodes ID, carries controls through
// ID/EX, EX/MEM and MEM/WB, and resolves load-use stalls, branch/jump flushes and bubbles.
module ctrl_pipe #(
  parameter int RA_W        = 5,
  parameter int ALUOP_W     = 3,
  parameter int EN_LU_STALL = 1
) (
  input logic         clk,
  input logic         reset,
  ctrl_pipe_if.slave  bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  typedef struct packed {
    logic               regwrite;
    logic               alusrc;
    logic               branch;
    logic               bne;
    logic               memwrite;
    logic               memtoreg;
    logic               lb;
    logic [ALUOP_W-1:0] aluop;
    logic [RA_W-1:0]    wa;
  } idex_t;

  typedef struct packed {
    logic            regwrite;
    logic            memwrite;
    logic            memtoreg;
    logic            lb;
    logic [RA_W-1:0] wa;
  } exmem_t;

  typedef struct packed {
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] wa;
  } memwb_t;

  idex_t  idex_q,  idex_d,  idex_dec;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic dec_known, dec_regdst, dec_jump, uses_rt, uses_rs;
  logic lu_hit, lu_hazard, stall_id, flush_if;

  // Decode; unknown opcodes and empty ID slots fall through as an all-zero bubble.
  always_comb begin
    idex_dec   = '0;
    dec_known  = 1'b1;
    dec_regdst = 1'b0;
    dec_jump   = 1'b0;
    unique case (bus.id_op)
      OP_R:    begin idex_dec.regwrite = 1'b1; dec_regdst = 1'b1; idex_dec.aluop = ALUOP_W'(3'b010); end
      OP_LW:   begin idex_dec.regwrite = 1'b1; idex_dec.alusrc = 1'b1; idex_dec.memtoreg = 1'b1; end
      OP_LB:   begin idex_dec.regwrite = 1'b1; idex_dec.alusrc = 1'b1; idex_dec.memtoreg = 1'b1;
                     idex_dec.lb = 1'b1; end
      OP_SW:   begin idex_dec.alusrc = 1'b1; idex_dec.memwrite = 1'b1; end
      OP_BEQ:  begin idex_dec.branch = 1'b1; idex_dec.aluop = ALUOP_W'(3'b001); end
      OP_BNE:  begin idex_dec.bne = 1'b1; idex_dec.aluop = ALUOP_W'(3'b001); end
      OP_ADDI: begin idex_dec.regwrite = 1'b1; idex_dec.alusrc = 1'b1; end
      OP_ANDI: begin idex_dec.regwrite = 1'b1; idex_dec.alusrc = 1'b1; idex_dec.aluop = ALUOP_W'(3'b011); end
      OP_ORI:  begin idex_dec.regwrite = 1'b1; idex_dec.alusrc = 1'b1; idex_dec.aluop = ALUOP_W'(3'b100); end
      OP_SLTI: begin idex_dec.regwrite = 1'b1; idex_dec.alusrc = 1'b1; idex_dec.aluop = ALUOP_W'(3'b101); end
      OP_J:    dec_jump = 1'b1;
      default: dec_known = 1'b0;
    endcase
    idex_dec.wa = dec_regdst ? bus.id_rd : bus.id_rt;
    if (!bus.id_valid || !dec_known) begin
      idex_dec = '0;
      dec_jump = 1'b0;
    end
  end

  assign uses_rt = (bus.id_op == OP_R) || (bus.id_op == OP_SW) ||
                   (bus.id_op == OP_BEQ) || (bus.id_op == OP_BNE);
  assign uses_rs = (bus.id_op != OP_J);

  // Register 0 never carries a hazard even when a load targets it.
  assign lu_hit = idex_q.memtoreg && idex_q.regwrite && (idex_q.wa != '0) && bus.id_valid &&
                  (((idex_q.wa == bus.id_rs) && uses_rs) || ((idex_q.wa == bus.id_rt) && uses_rt));
  assign lu_hazard = (EN_LU_STALL != 0) && lu_hit;

  always_comb begin
    idex_d   = idex_q;
    exmem_d  = exmem_q;
    memwb_d  = memwb_q;
    stall_id = 1'b0;
    flush_if = 1'b0;
    if (!bus.stall_ext) begin
      exmem_d = '{regwrite: idex_q.regwrite, memwrite: idex_q.memwrite,
                  memtoreg: idex_q.memtoreg, lb: idex_q.lb, wa: idex_q.wa};
      memwb_d = '{regwrite: exmem_q.regwrite, memtoreg: exmem_q.memtoreg, wa: exmem_q.wa};
      idex_d  = '0;
      if (bus.ex_taken)     flush_if = 1'b1;
      else if (lu_hazard)   stall_id = 1'b1;
      else if (dec_jump)    flush_if = 1'b1;
      else                  idex_d   = idex_dec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign bus.stall_id     = stall_id;
  assign bus.flush_if     = flush_if;
  assign bus.illegal      = bus.id_valid && !dec_known;
  assign bus.ex_regwrite  = idex_q.regwrite;
  assign bus.ex_alusrc    = idex_q.alusrc;
  assign bus.ex_branch    = idex_q.branch;
  assign bus.ex_bne       = idex_q.bne;
  assign bus.ex_memwrite  = idex_q.memwrite;
  assign bus.ex_memtoreg  = idex_q.memtoreg;
  assign bus.ex_lb        = idex_q.lb;
  assign bus.ex_aluop     = idex_q.aluop;
  assign bus.ex_wa        = idex_q.wa;
  assign bus.mem_regwrite = exmem_q.regwrite;
  assign bus.mem_memwrite = exmem_q.memwrite;
  assign bus.mem_memtoreg = exmem_q.memtoreg;
  assign bus.mem_lb       = exmem_q.lb;
  assign bus.mem_wa       = exmem_q.wa;
  assign bus.wb_regwrite  = memwb_q.regwrite;
  assign bus.wb_memtoreg  = memwb_q.memtoreg;
  assign bus.wb_wa        = memwb_q.wa;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: one DUT with load-use detection and one without,
// both fed the same ID stream.
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.RA_W(5), .ALUOP_W(3)) bus ();
  ctrl_pipe_if #(.RA_W(5), .ALUOP_W(3)) bus0 ();

  ctrl_pipe #(.RA_W(5), .ALUOP_W(3), .EN_LU_STALL(1)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  ctrl_pipe #(.RA_W(5), .ALUOP_W(3), .EN_LU_STALL(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  logic [30:0] outs;
  logic [9:0]  exv;
  assign exv  = {bus.ex_regwrite, bus.ex_alusrc, bus.ex_branch, bus.ex_bne, bus.ex_memwrite,
                 bus.ex_memtoreg, bus.ex_lb, bus.ex_aluop};
  assign outs = {exv, bus.ex_wa, bus.mem_regwrite, bus.mem_memwrite, bus.mem_memtoreg, bus.mem_lb,
                 bus.mem_wa, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_wa};

  localparam logic [5:0] R = 6'h00, LW = 6'h23, ADDI = 6'h08, J = 6'h02;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rd);
    bus.id_valid = v;  bus.id_op = op;  bus.id_rs = rs;  bus.id_rt = rt;  bus.id_rd = rd;
    bus0.id_valid = v; bus0.id_op = op; bus0.id_rs = rs; bus0.id_rt = rt; bus0.id_rd = rd;
    #1;
  endtask

  task automatic ctl(input logic s, input logic t);
    bus.stall_ext = s;  bus.ex_taken = t;
    bus0.stall_ext = s; bus0.ex_taken = t;
    #1;
  endtask

  task automatic test_reset();
    drive(0, R, 0, 0, 0);
    ctl(0, 0);
    step(); step();
    checks++; if (outs !== '0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
    checks++; if ({bus.stall_id, bus.flush_if} !== 2'b00) begin failures++;
      $display("FAIL reset_hazard got=%b exp=00", {bus.stall_id, bus.flush_if}); end
    reset = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_decode();
    logic [5:0] ops [10];
    logic [9:0] ev  [10];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h20, 6'h0C, 6'h0D, 6'h0A};
    ev  = '{10'b1000000010, 10'b1100010000, 10'b0100100000, 10'b0010000001, 10'b0001000001,
            10'b1100000000, 10'b1100011000, 10'b1100000011, 10'b1100000100, 10'b1100000101};
    for (int i = 0; i < 10; i++) begin
      drive(1, ops[i], 5'd1, 5'd2, 5'd3);
      step();
      checks++; if (exv !== ev[i]) begin failures++;
        $display("FAIL decode_op%h got=%b exp=%b", ops[i], exv, ev[i]); end
      checks++; if (bus.ex_wa !== ((i == 0) ? 5'd3 : 5'd2)) begin failures++;
        $display("FAIL decode_wa_op%h got=%0d exp=%0d", ops[i], bus.ex_wa, (i == 0) ? 3 : 2); end
      $display("decode op=%h ex=%b wa=%0d", ops[i], exv, bus.ex_wa);
      drive(0, R, 0, 0, 0);
      step();
    end
  endtask

  task automatic test_latency();
    drive(1, LW, 5'd10, 5'd9, 5'd3);
    step();
    checks++; if ({bus.ex_memtoreg, bus.ex_wa} !== {1'b1, 5'd9}) begin failures++;
      $display("FAIL lat_ex got=%b/%0d exp=1/9", bus.ex_memtoreg, bus.ex_wa); end
    drive(1, ADDI, 5'd4, 5'd11, 5'd0);
    step();
    checks++; if ({bus.mem_memtoreg, bus.mem_regwrite, bus.mem_wa} !== {2'b11, 5'd9}) begin failures++;
      $display("FAIL lat_mem got=%b%b/%0d exp=11/9", bus.mem_memtoreg, bus.mem_regwrite, bus.mem_wa); end
    checks++; if ({bus.ex_regwrite, bus.ex_memtoreg, bus.ex_wa} !== {2'b10, 5'd11}) begin failures++;
      $display("FAIL lat_addi got=%b%b/%0d exp=10/11", bus.ex_regwrite, bus.ex_memtoreg, bus.ex_wa); end
    drive(0, R, 0, 0, 0);
    step();
    checks++; if ({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_wa} !== {2'b11, 5'd9}) begin failures++;
      $display("FAIL lat_wb got=%b%b/%0d exp=11/9", bus.wb_regwrite, bus.wb_memtoreg, bus.wb_wa); end
    $display("latency wb_wa=%0d", bus.wb_wa);
    step(); step();
  endtask

  task automatic test_load_use();
    drive(1, LW, 5'd1, 5'd8, 5'd0);
    step();
    drive(1, R, 5'd2, 5'd8, 5'd5);
    checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", bus.stall_id); end
    checks++; if (bus0.stall_id !== 1'b0) begin failures++; $display("FAIL lu_nostall_en0 got=%b exp=0", bus0.stall_id); end
    step();
    checks++; if ({bus.ex_regwrite, bus.ex_memtoreg, bus.mem_memtoreg} !== 3'b001) begin failures++;
      $display("FAIL lu_bubble got=%b exp=001", {bus.ex_regwrite, bus.ex_memtoreg, bus.mem_memtoreg}); end
    checks++; if ({bus0.ex_regwrite, bus0.ex_wa} !== {1'b1, 5'd5}) begin failures++;
      $display("FAIL lu_en0_issue got=%b/%0d exp=1/5", bus0.ex_regwrite, bus0.ex_wa); end
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL lu_one_cycle got=%b exp=0", bus.stall_id); end
    step();
    checks++; if ({bus.ex_regwrite, bus.ex_wa} !== {1'b1, 5'd5}) begin failures++;
      $display("FAIL lu_issue got=%b/%0d exp=1/5", bus.ex_regwrite, bus.ex_wa); end
    $display("load_use ex_wa=%0d", bus.ex_wa);
    drive(0, R, 0, 0, 0);
    step(); step(); step();
  endtask

  task automatic test_reg0();
    drive(1, LW, 5'd1, 5'd0, 5'd0);
    step();
    drive(1, R, 5'd0, 5'd4, 5'd5);
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b exp=0", bus.stall_id); end
    drive(0, R, 0, 0, 0);
    step(); step();
    checks++; if ({bus.wb_regwrite, bus.wb_wa} !== {1'b1, 5'd0}) begin failures++;
      $display("FAIL r0_wb got=%b/%0d exp=1/0", bus.wb_regwrite, bus.wb_wa); end
    drive(1, LW, 5'd1, 5'd8, 5'd0);
    step();
    drive(1, ADDI, 5'd3, 5'd8, 5'd0);
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("FAIL addi_rt_stall got=%b exp=0", bus.stall_id); end
    drive(1, ADDI, 5'd8, 5'd3, 5'd0);
    checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("FAIL addi_rs_stall got=%b exp=1", bus.stall_id); end
    $display("reg0 / non-user checks done");
    drive(0, R, 0, 0, 0);
    step(); step(); step();
  endtask

  task automatic test_flush();
    drive(1, LW, 5'd1, 5'd8, 5'd0);
    step();
    drive(1, R, 5'd2, 5'd8, 5'd5);
    ctl(0, 1);
    checks++; if ({bus.flush_if, bus.stall_id} !== 2'b10) begin failures++;
      $display("FAIL flush_prio got=%b exp=10", {bus.flush_if, bus.stall_id}); end
    step();
    checks++; if ({exv, bus.mem_memtoreg} !== 11'b00000000001) begin failures++;
      $display("FAIL flush_bubble got=%b exp=00000000001", {exv, bus.mem_memtoreg}); end
    ctl(0, 0);
    drive(1, J, 5'd0, 5'd0, 5'd0);
    checks++; if (bus.flush_if !== 1'b1) begin failures++; $display("FAIL j_flush got=%b exp=1", bus.flush_if); end
    step();
    drive(0, R, 0, 0, 0);
    checks++; if ({exv, bus.flush_if} !== 11'b0) begin failures++;
      $display("FAIL j_bubble got=%b exp=0", {exv, bus.flush_if}); end
    $display("flush checks done");
    step(); step(); step();
  endtask

  task automatic test_ext_stall();
    drive(1, LW, 5'd1, 5'd12, 5'd0);
    step();
    drive(1, ADDI, 5'd1, 5'd7, 5'd0);
    step();
    drive(1, R, 5'd2, 5'd3, 5'd6);
    ctl(1, 1);
    checks++; if ({bus.flush_if, bus.stall_id} !== 2'b00) begin failures++;
      $display("FAIL xs_ctrl got=%b exp=00", {bus.flush_if, bus.stall_id}); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({bus.ex_regwrite, bus.ex_wa, bus.mem_memtoreg, bus.mem_wa, bus.flush_if} !==
                    {1'b1, 5'd7, 1'b1, 5'd12, 1'b0}) begin failures++;
        $display("FAIL xs_hold%0d got=%b/%0d/%b/%0d/%b exp=1/7/1/12/0", i, bus.ex_regwrite, bus.ex_wa,
                 bus.mem_memtoreg, bus.mem_wa, bus.flush_if); end
    end
    ctl(0, 1);
    checks++; if (bus.flush_if !== 1'b1) begin failures++; $display("FAIL xs_release got=%b exp=1", bus.flush_if); end
    step();
    checks++; if ({bus.ex_regwrite, bus.mem_regwrite, bus.mem_wa, bus.wb_memtoreg, bus.wb_wa} !==
                  {2'b01, 5'd7, 1'b1, 5'd12}) begin failures++;
      $display("FAIL xs_after got=%b%b/%0d/%b/%0d exp=01/7/1/12", bus.ex_regwrite, bus.mem_regwrite,
               bus.mem_wa, bus.wb_memtoreg, bus.wb_wa); end
    $display("ext_stall checks done");
    ctl(0, 0);
    drive(0, R, 0, 0, 0);
    step(); step(); step();
  endtask

  task automatic test_illegal();
    drive(1, 6'h3F, 5'd1, 5'd2, 5'd3);
    checks++; if (bus.illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag got=%b exp=1", bus.illegal); end
    step();
    checks++; if ({exv, bus.ex_wa} !== 15'b0) begin failures++;
      $display("FAIL illegal_bubble got=%b exp=0", {exv, bus.ex_wa}); end
    drive(0, 6'h3F, 5'd1, 5'd2, 5'd3);
    checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL illegal_invalid got=%b exp=0", bus.illegal); end
    $display("illegal checks done");
    step();
  endtask

  task automatic test_reset_mid();
    drive(1, LW, 5'd1, 5'd9, 5'd0);
    step();
    drive(1, ADDI, 5'd1, 5'd4, 5'd0);
    step();
    #2 reset = 1'b0;
    #1;
    checks++; if (outs !== '0) begin failures++; $display("FAIL rst_mid got=%h exp=0", outs); end
    drive(0, R, 0, 0, 0);
    step();
    reset = 1'b1;
    step(); step(); step();
    checks++; if (outs !== '0) begin failures++; $display("FAIL rst_after got=%h exp=0", outs); end
    $display("reset_mid checks done");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_latency();
    test_load_use();
    test_reg0();
    test_flush();
    test_ext_stall();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
